// File: rtl/mouse_overlay_pipe.sv
// Arrow-cursor overlay for the VGA stream: position/mode latched at vblank start,
// two-stage pipeline with identical 2-clk latency on every output.
module mouse_overlay_pipe #(
   parameter int CNT_W   = 12,
   parameter int COLOR_W = 4,
   parameter int CUR_W   = 12,
   parameter int CUR_H   = 16,
   parameter logic [3*COLOR_W-1:0] FILL_RGB = 12'hFFF,
   parameter logic [3*COLOR_W-1:0] EDGE_RGB = 12'h000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [CNT_W-1:0]       xpos_in,
   input  logic [CNT_W-1:0]       ypos_in,
   input  logic [1:0]             mode_in,
   input  logic [CNT_W-1:0]       hcount_in,
   input  logic [CNT_W-1:0]       vcount_in,
   input  logic                   hblnk_in,
   input  logic                   vblnk_in,
   input  logic                   hs_in,
   input  logic                   vs_in,
   input  logic [3*COLOR_W-1:0]   rgb_in,
   output logic [CNT_W-1:0]       hcount_out,
   output logic [CNT_W-1:0]       vcount_out,
   output logic                   hblnk_out,
   output logic                   vblnk_out,
   output logic                   hs_out,
   output logic                   vs_out,
   output logic [3*COLOR_W-1:0]   rgb_out
);

   localparam int RGB_W = 3*COLOR_W;
   localparam logic [CNT_W:0] CUR_W_L  = (CNT_W+1)'(CUR_W);
   localparam logic [CNT_W:0] CUR_H_L  = (CNT_W+1)'(CUR_H);
   localparam logic [CNT_W:0] CUR_W_M1 = (CNT_W+1)'(CUR_W-1);
   localparam logic [CNT_W:0] CUR_H_M1 = (CNT_W+1)'(CUR_H-1);

   logic             vblnk_prev_q;
   logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
   logic [1:0]       mode_q, mode_d;
   logic             latch_d;

   logic [CNT_W:0]   dx_d, dy_d;
   logic             inside_d, is_edge_d;

   logic             s1_inside_q, s1_edge_q, s1_hb_q, s1_vb_q, s1_hs_q, s1_vs_q;
   logic [CNT_W-1:0] s1_hc_q, s1_vc_q;
   logic [RGB_W-1:0] s1_rgb_q;
   logic [1:0]       s1_mode_q;
   logic [RGB_W-1:0] rgb_d;

   // Position and mode only move on the rising edge of vblank so the cursor never tears.
   assign latch_d = vblnk_in & ~vblnk_prev_q;

   always_comb begin
      x_d    = x_q;
      y_d    = y_q;
      mode_d = mode_q;
      if (latch_d) begin
         x_d    = xpos_in;
         y_d    = ypos_in;
         mode_d = mode_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vblnk_prev_q <= 1'b0;
         x_q          <= '0;
         y_q          <= '0;
         mode_q       <= 2'b00;
      end else begin
         vblnk_prev_q <= vblnk_in;
         x_q          <= x_d;
         y_q          <= y_d;
         mode_q       <= mode_d;
      end
   end

   // Offsets carry an extra sign bit; a set MSB means the pixel is left of / above the tip.
   assign dx_d = {1'b0, hcount_in} - {1'b0, x_q};
   assign dy_d = {1'b0, vcount_in} - {1'b0, y_q};

   assign inside_d  = ~dx_d[CNT_W] & ~dy_d[CNT_W] & (dy_d < CUR_H_L) &
                      (dx_d < CUR_W_L) & (dx_d <= dy_d);
   assign is_edge_d = inside_d & ((dx_d == '0) | (dx_d == dy_d) |
                                  (dy_d == CUR_H_M1) | (dx_d == CUR_W_M1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_inside_q <= 1'b0;
         s1_edge_q   <= 1'b0;
         s1_hb_q     <= 1'b0;
         s1_vb_q     <= 1'b0;
         s1_hs_q     <= 1'b0;
         s1_vs_q     <= 1'b0;
         s1_hc_q     <= '0;
         s1_vc_q     <= '0;
         s1_rgb_q    <= '0;
         s1_mode_q   <= 2'b00;
      end else begin
         s1_inside_q <= inside_d;
         s1_edge_q   <= is_edge_d;
         s1_hb_q     <= hblnk_in;
         s1_vb_q     <= vblnk_in;
         s1_hs_q     <= hs_in;
         s1_vs_q     <= vs_in;
         s1_hc_q     <= hcount_in;
         s1_vc_q     <= vcount_in;
         s1_rgb_q    <= rgb_in;
         s1_mode_q   <= mode_q;
      end
   end

   always_comb begin
      rgb_d = s1_rgb_q;
      if (s1_hb_q | s1_vb_q) begin
         rgb_d = '0;
      end else begin
         case (s1_mode_q)
            2'b01: begin
               if (s1_edge_q)        rgb_d = EDGE_RGB;
               else if (s1_inside_q) rgb_d = FILL_RGB;
            end
            2'b10: begin
               if (s1_inside_q) rgb_d = ~s1_rgb_q;
            end
            2'b11: begin
               if (s1_edge_q) rgb_d = EDGE_RGB;
            end
            default: rgb_d = s1_rgb_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hcount_out <= '0;
         vcount_out <= '0;
         hblnk_out  <= 1'b0;
         vblnk_out  <= 1'b0;
         hs_out     <= 1'b0;
         vs_out     <= 1'b0;
         rgb_out    <= '0;
      end else begin
         hcount_out <= s1_hc_q;
         vcount_out <= s1_vc_q;
         hblnk_out  <= s1_hb_q;
         vblnk_out  <= s1_vb_q;
         hs_out     <= s1_hs_q;
         vs_out     <= s1_vs_q;
         rgb_out    <= rgb_d;
      end
   end

endmodule

// File: tb/tb_mouse_overlay_pipe.sv
// Scoreboard bench for mouse_overlay_pipe: expected pixels are queued when driven
// and compared two clocks later against the DUT outputs.
module tb_mouse_overlay_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] xpos_in, ypos_in, hcount_in, vcount_in, rgb_in;
   logic [1:0]  mode_in;
   logic        hblnk_in, vblnk_in, hs_in, vs_in;
   logic [11:0] hcount_out, vcount_out, rgb_out;
   logic        hblnk_out, vblnk_out, hs_out, vs_out;

   mouse_overlay_pipe dut (
      .clk(clk), .rst(rst),
      .xpos_in(xpos_in), .ypos_in(ypos_in), .mode_in(mode_in),
      .hcount_in(hcount_in), .vcount_in(vcount_in),
      .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .hs_in(hs_in), .vs_in(vs_in),
      .rgb_in(rgb_in),
      .hcount_out(hcount_out), .vcount_out(vcount_out),
      .hblnk_out(hblnk_out), .vblnk_out(vblnk_out), .hs_out(hs_out), .vs_out(vs_out),
      .rgb_out(rgb_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [27:0] ctl;
      logic [11:0] rgb;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0;
   int   n_err = 0;

   int   m_x = 0, m_y = 0;
   logic [1:0] m_mode = 2'b00;
   logic m_vprev = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, got, want);
      end
   endtask

   function automatic logic [11:0] model_rgb(input int h, input int v, input logic blank,
                                             input logic [11:0] bg);
      int   dx, dy;
      logic ins, edg;
      dx  = h - m_x;
      dy  = v - m_y;
      ins = (dx >= 0) && (dy >= 0) && (dy < 16) && (dx < 12) && (dx <= dy);
      edg = ins && (dx == 0 || dx == dy || dy == 15 || dx == 11);
      if (blank) return 12'h000;
      case (m_mode)
         2'b01:   return edg ? 12'h000 : (ins ? 12'hFFF : bg);
         2'b10:   return ins ? ~bg : bg;
         2'b11:   return edg ? 12'h000 : bg;
         default: return bg;
      endcase
   endfunction

   function automatic logic [27:0] out_ctl();
      return {hcount_out, vcount_out, hblnk_out, vblnk_out, hs_out, vs_out};
   endfunction

   // One pixel per clock; use_k selects a hand-derived expected colour instead of the model.
   task automatic px(input int h, input int v, input logic hb, input logic vb,
                     input logic hs, input logic vs, input logic [11:0] bg,
                     input logic use_k, input logic [11:0] k, input string tag);
      exp_t e, o;
      hcount_in = 12'(h);
      vcount_in = 12'(v);
      hblnk_in  = hb;
      vblnk_in  = vb;
      hs_in     = hs;
      vs_in     = vs;
      rgb_in    = bg;
      e.tag = tag;
      e.ctl = {12'(h), 12'(v), hb, vb, hs, vs};
      e.rgb = use_k ? k : model_rgb(h, v, hb | vb, bg);
      q.push_back(e);
      if (vb && !m_vprev) begin
         m_x    = int'(xpos_in);
         m_y    = int'(ypos_in);
         m_mode = mode_in;
      end
      m_vprev = vb;
      @(posedge clk);
      #1;
      if (q.size() == 2) begin
         o = q.pop_front();
         chk({o.tag, "_rgb"}, {20'd0, rgb_out}, {20'd0, o.rgb});
         chk({o.tag, "_ctl"}, {4'd0, out_ctl()}, {4'd0, o.ctl});
      end
   endtask

   task automatic vbl();
      for (int i = 0; i < 3; i++) px(0, 600, 1'b1, 1'b1, 1'b0, 1'b1, 12'h0F0, 1'b0, 12'h0, "vbl");
   endtask

   task automatic win(input int x0, input int y0, input int w, input int hgt,
                      input logic [11:0] bg);
      for (int v = y0; v < y0 + hgt; v++)
         for (int h = x0; h < x0 + w; h++)
            px(h, v, 1'b0, 1'b0, 1'b0, 1'b0, bg, 1'b0, 12'h0, "win");
   endtask

   initial begin
      rst = 1'b1;
      xpos_in = 12'd0; ypos_in = 12'd0; mode_in = 2'b00;
      hcount_in = 12'd0; vcount_in = 12'd0; rgb_in = 12'h0;
      hblnk_in = 1'b0; vblnk_in = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_rgb", {20'd0, rgb_out}, 32'd0);
      chk("reset_ctl", {4'd0, out_ctl()}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Frame 1: mode not yet latched, cursor off.
      xpos_in = 12'd100; ypos_in = 12'd100; mode_in = 2'b01;
      win(98, 98, 16, 20, 12'h0F0);
      px(100, 100, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0F0, 1'b1, 12'h0F0, "t1_off");
      px(103, 110, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0F0, 1'b1, 12'h0F0, "t1_off_in");
      // Frame 2: solid cursor.
      vbl();
      win(98, 98, 16, 20, 12'h0F0);
      px(100, 100, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0F0, 1'b1, 12'h000, "t2_tip");
      px(100, 105, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0F0, 1'b1, 12'h000, "t2_left");
      px(103, 110, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0F0, 1'b1, 12'hFFF, "t2_fill");
      px(104, 103, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0F0, 1'b1, 12'h0F0, "t2_out");
      px(111, 115, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0F0, 1'b1, 12'h000, "t2_corner");

      // Xor mode.
      xpos_in = 12'd50; ypos_in = 12'd50; mode_in = 2'b10;
      vbl();
      px(52, 60, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123, 1'b1, 12'hEDC, "t3_inv");
      px(60, 52, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123, 1'b1, 12'h123, "t3_pass");
      win(48, 48, 14, 18, 12'h123);

      // Mid-frame position change waits for the next vblank.
      xpos_in = 12'd100; ypos_in = 12'd100; mode_in = 2'b01;
      vbl();
      for (int v = 100; v < 116; v++) begin
         if (v == 108) xpos_in = 12'd300;
         for (int h = 98; h < 114; h++)
            px(h, v, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0F0, 1'b0, 12'h0, "t4_win");
      end
      px(100, 110, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0F0, 1'b1, 12'h000, "t4_held");
      px(300, 110, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0F0, 1'b1, 12'h0F0, "t4_notyet");
      vbl();
      px(300, 110, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0F0, 1'b1, 12'h000, "t4_moved");
      px(100, 110, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0F0, 1'b1, 12'h0F0, "t4_left");

      // Clipping at the bottom-right corner.
      xpos_in = 12'd795; ypos_in = 12'd595; mode_in = 2'b01;
      vbl();
      for (int v = 592; v < 600; v++)
         for (int h = 792; h < 808; h++)
            px(h, v, (h >= 800), 1'b0, 1'b0, 1'b0, 12'h0F0, 1'b0, 12'h0, "t5_win");
      px(796, 599, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0F0, 1'b1, 12'hFFF, "t5_fill");
      px(800, 605, 1'b1, 1'b0, 1'b0, 1'b0, 12'h0F0, 1'b1, 12'h000, "t5_hblank");
      px(2, 5, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0F0, 1'b1, 12'h0F0, "t5_nowrap");
      px(797, 605, 1'b0, 1'b1, 1'b0, 1'b0, 12'h0F0, 1'b1, 12'h000, "t5_vblank");

      // Random control/timing stimulus.
      for (int i = 0; i < 400; i++) begin
         xpos_in = 12'($urandom_range(0, 40));
         ypos_in = 12'($urandom_range(0, 40));
         mode_in = 2'($urandom_range(0, 3));
         px(int'($urandom_range(0, 70)), int'($urandom_range(0, 70)),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            12'($urandom_range(0, 4095)), 1'b0, 12'h0, "t6_rand");
      end

      // Reset in the middle of a line.
      px(5, 5, 1'b0, 1'b0, 1'b1, 1'b1, 12'hABC, 1'b0, 12'h0, "t6_pre");
      px(6, 5, 1'b0, 1'b0, 1'b1, 1'b1, 12'hABC, 1'b0, 12'h0, "t6_pre");
      rst = 1'b1;
      #1;
      chk("t6_rst_rgb", {20'd0, rgb_out}, 32'd0);
      chk("t6_rst_ctl", {4'd0, out_ctl()}, 32'd0);
      q.delete();
      m_x = 0; m_y = 0; m_mode = 2'b00; m_vprev = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      xpos_in = 12'd0; ypos_in = 12'd0; mode_in = 2'b01;
      px(2, 5, 1'b0, 1'b0, 1'b1, 1'b1, 12'h0F0, 1'b0, 12'h0, "t6_post");
      chk("t6_pipe0_rgb", {20'd0, rgb_out}, 32'd0);
      chk("t6_pipe0_ctl", {4'd0, out_ctl()}, 32'd0);
      px(1, 3, 1'b0, 1'b0, 1'b1, 1'b0, 12'h0F0, 1'b1, 12'h0F0, "t6_off");
      px(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h0F0, 1'b1, 12'h0F0, "t6_off_tip");
      px(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0F0, 1'b0, 12'h0, "drain");
      px(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0F0, 1'b0, 12'h0, "drain");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
